// File: rtl/retire_recovery_ctrl.sv
// Precise-state recovery sequencer: squash, banked map-table restore, freelist restore,
// FU drain and fetch redirect. Optional perf counters via RECOVER_PERF_CNT_EN.

`ifndef ROB
`define ROB 5
`endif

module retire_recovery_ctrl #(
    parameter int CHUNK     = 8,
    parameter int DRAIN_MAX = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             recover_req,
    input  logic [31:0]      recover_pc,
    input  logic [`ROB-1:0]  recover_fl_head,
    input  logic             fu_busy,
    output logic             squash,
    output logic             dispatch_stall,
    output logic             retire_stall,
    output logic             mt_restore_en,
    output logic [4:0]       mt_restore_base,
    output logic             fl_restore_en,
    output logic [`ROB-1:0]  fl_restore_head,
    output logic             fetch_redirect,
    output logic [31:0]      redirect_pc,
    output logic             recover_busy
`ifdef RECOVER_PERF_CNT_EN
    ,
    output logic [31:0]      recover_count,
    output logic [31:0]      recover_stall_cycles
`endif
);

    localparam int NCHUNK = 32 / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
    localparam logic [3:0]    DMAX   = 4'(DRAIN_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_RESTORE,
        S_DRAIN,
        S_RESUME
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    chunk_q, chunk_d;
    logic [3:0]       drain_q, drain_d;
    logic [31:0]      pc_q, pc_d;
    logic [`ROB-1:0]  head_q, head_d;
    logic             accept;

    logic             squash_q, squash_d;
    logic             busy_q, busy_d;
    logic             mt_en_q, mt_en_d;
    logic [4:0]       base_q, base_d;
    logic             fl_en_q, fl_en_d;
    logic             redirect_q, redirect_d;

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            chunk_q    <= '0;
            drain_q    <= '0;
            pc_q       <= '0;
            head_q     <= '0;
            squash_q   <= 1'b0;
            busy_q     <= 1'b0;
            mt_en_q    <= 1'b0;
            base_q     <= '0;
            fl_en_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            drain_q    <= drain_d;
            pc_q       <= pc_d;
            head_q     <= head_d;
            squash_q   <= squash_d;
            busy_q     <= busy_d;
            mt_en_q    <= mt_en_d;
            base_q     <= base_d;
            fl_en_q    <= fl_en_d;
            redirect_q <= redirect_d;
        end
    end

    // Next-state logic; requests outside IDLE are dropped since retire is stalled
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        drain_d = drain_q;
        pc_d    = pc_q;
        head_d  = head_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (recover_req) begin
                    accept  = 1'b1;
                    pc_d    = recover_pc;
                    head_d  = recover_fl_head;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                chunk_d = '0;
                state_d = S_RESTORE;
            end
            S_RESTORE: begin
                if (chunk_q == K_LAST) begin
                    chunk_d = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!fu_busy || drain_q == DMAX) begin
                    state_d = S_RESUME;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_RESUME: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear registered (Moore)
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        squash_d   = (state_d == S_FLUSH) ||
                     ((state_d == S_DRAIN) && (drain_d == DMAX));
        mt_en_d    = (state_d == S_RESTORE);
        base_d     = (state_d == S_RESTORE) ? 5'(chunk_d * CHUNK) : 5'd0;
        fl_en_d    = (state_d == S_RESTORE) && (chunk_d == K_LAST);
        redirect_d = (state_d == S_RESUME);
    end

    assign squash          = squash_q;
    assign dispatch_stall  = busy_q;
    assign retire_stall    = busy_q;
    assign recover_busy    = busy_q;
    assign mt_restore_en   = mt_en_q;
    assign mt_restore_base = base_q;
    assign fl_restore_en   = fl_en_q;
    assign fl_restore_head = head_q;
    assign fetch_redirect  = redirect_q;
    assign redirect_pc     = pc_q;

`ifdef RECOVER_PERF_CNT_EN
    logic [31:0] rcnt_q, rcnt_d;
    logic [31:0] scnt_q, scnt_d;

    always_comb begin
        rcnt_d = rcnt_q;
        scnt_d = scnt_q;
        if (accept && rcnt_q != 32'hFFFF_FFFF) begin
            rcnt_d = rcnt_q + 32'd1;
        end
        if (busy_q && scnt_q != 32'hFFFF_FFFF) begin
            scnt_d = scnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign recover_count        = rcnt_q;
    assign recover_stall_cycles = scnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_retire_recovery_ctrl.sv
// Table-driven bench for retire_recovery_ctrl plus hand-written DRAIN-timeout and
// perf-counter sequences (the latter only when RECOVER_PERF_CNT_EN is defined).

module tb_retire_recovery_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        recover_req;
    logic [31:0] recover_pc;
    logic [4:0]  recover_fl_head;
    logic        fu_busy;
    logic        squash, dispatch_stall, retire_stall, mt_restore_en;
    logic [4:0]  mt_restore_base;
    logic        fl_restore_en;
    logic [4:0]  fl_restore_head;
    logic        fetch_redirect;
    logic [31:0] redirect_pc;
    logic        recover_busy;
`ifdef RECOVER_PERF_CNT_EN
    logic [31:0] recover_count, recover_stall_cycles;
`endif

    always #5 clock = ~clock;

    retire_recovery_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .recover_req     (recover_req),
        .recover_pc      (recover_pc),
        .recover_fl_head (recover_fl_head),
        .fu_busy         (fu_busy),
        .squash          (squash),
        .dispatch_stall  (dispatch_stall),
        .retire_stall    (retire_stall),
        .mt_restore_en   (mt_restore_en),
        .mt_restore_base (mt_restore_base),
        .fl_restore_en   (fl_restore_en),
        .fl_restore_head (fl_restore_head),
        .fetch_redirect  (fetch_redirect),
        .redirect_pc     (redirect_pc),
        .recover_busy    (recover_busy)
`ifdef RECOVER_PERF_CNT_EN
        ,
        .recover_count        (recover_count),
        .recover_stall_cycles (recover_stall_cycles)
`endif
    );

    // One row = inputs held for one cycle + outputs expected right after that edge
    typedef struct {
        logic        rstn;
        logic        req;
        logic [31:0] pc;
        logic [4:0]  hd;
        logic        fb;
        logic        sq;
        logic        st;
        logic        mt;
        logic [4:0]  base;
        logic        fl;
        logic        rd;
        logic [4:0]  ehd;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rstn, input logic req, input logic [31:0] pc,
                       input logic [4:0] hd, input logic fb, input logic sq,
                       input logic st, input logic mt, input logic [4:0] base,
                       input logic fl, input logic rd, input logic [4:0] ehd,
                       input logic [31:0] epc);
        vec_t v;
        v.rstn = rstn; v.req = req; v.pc = pc; v.hd = hd; v.fb = fb;
        v.sq = sq; v.st = st; v.mt = mt; v.base = base; v.fl = fl; v.rd = rd;
        v.ehd = ehd; v.epc = epc;
        vecs.push_back(v);
    endtask

    // Full recovery from IDLE with nbusy extra DRAIN cycles (nbusy < 15)
    task automatic seq(input logic [31:0] pc, input logic [4:0] hd, input int nbusy);
        add(1, 1, pc, hd, 0,  1, 1, 0, 5'd0,  0, 0, hd, pc);
        add(1, 0, 0, 0, 0,    0, 1, 1, 5'd0,  0, 0, hd, pc);
        add(1, 0, 0, 0, 0,    0, 1, 1, 5'd8,  0, 0, hd, pc);
        add(1, 0, 0, 0, 0,    0, 1, 1, 5'd16, 0, 0, hd, pc);
        add(1, 0, 0, 0, 0,    0, 1, 1, 5'd24, 1, 0, hd, pc);
        add(1, 0, 0, 0, (nbusy > 0), 0, 1, 0, 5'd0, 0, 0, hd, pc);
        for (int i = 0; i < nbusy; i++)
            add(1, 0, 0, 0, 1, 0, 1, 0, 5'd0, 0, 0, hd, pc);
        add(1, 0, 0, 0, 0,    0, 1, 0, 5'd0,  0, 1, hd, pc);
        add(1, 0, 0, 0, 0,    0, 0, 0, 5'd0,  0, 0, hd, pc);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] got, exp;
        int          sq_first, sq_second, sq_n, rd_cyc;
        logic [31:0] rd_pc;
`ifdef RECOVER_PERF_CNT_EN
        logic [31:0] c0, s0;
`endif
        reset = 1'b0; recover_req = 1'b0; recover_pc = '0;
        recover_fl_head = '0; fu_busy = 1'b0;

        // Reset held 3 cycles with a pending request, then one idle cycle
        for (int i = 0; i < 3; i++)
            add(0, 1, 32'h0000_1234, 5'd7, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        // Nominal recovery, then back-to-back recovery with 4 busy DRAIN cycles
        seq(32'h0000_1040, 5'd5, 0);
        seq(32'h0000_2000, 5'd17, 4);
        // Requests during the sequence are ignored; next IDLE request is accepted
        add(1, 1, 32'h0000_1040, 5'd5, 0, 1, 1, 0, 5'd0, 0, 0, 5'd5, 32'h0000_1040);
        add(1, 0, 0, 0, 0, 0, 1, 1, 5'd0, 0, 0, 5'd5, 32'h0000_1040);
        add(1, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 0, 5'd5, 32'h0000_1040);
        add(1, 1, 32'hFFFF_0000, 5'd9, 0, 0, 1, 1, 5'd16, 0, 0, 5'd5, 32'h0000_1040);
        add(1, 0, 0, 0, 0, 0, 1, 1, 5'd24, 1, 0, 5'd5, 32'h0000_1040);
        add(1, 1, 32'hFFFF_0000, 5'd9, 0, 0, 1, 0, 5'd0, 0, 0, 5'd5, 32'h0000_1040);
        add(1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 0, 1, 5'd5, 32'h0000_1040);
        add(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd5, 32'h0000_1040);
        seq(32'h0000_3000, 5'd2, 0);
        // Reset mid-RESTORE aborts with everything cleared and no redirect
        add(1, 1, 32'h0000_5550, 5'd12, 0, 1, 1, 0, 5'd0, 0, 0, 5'd12, 32'h0000_5550);
        add(1, 0, 0, 0, 0, 0, 1, 1, 5'd0,  0, 0, 5'd12, 32'h0000_5550);
        add(1, 0, 0, 0, 0, 0, 1, 1, 5'd8,  0, 0, 5'd12, 32'h0000_5550);
        add(1, 0, 0, 0, 0, 0, 1, 1, 5'd16, 0, 0, 5'd12, 32'h0000_5550);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 6; i++)
            add(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rstn;
            recover_req     = vecs[i].req;
            recover_pc      = vecs[i].pc;
            recover_fl_head = vecs[i].hd;
            fu_busy         = vecs[i].fb;
            @(negedge clock);
            got = {15'd0, squash, dispatch_stall, retire_stall, mt_restore_en,
                   mt_restore_base, fl_restore_en, fl_restore_head, fetch_redirect,
                   redirect_pc, recover_busy};
            exp = {15'd0, vecs[i].sq, vecs[i].st, vecs[i].st, vecs[i].mt,
                   vecs[i].base, vecs[i].fl, vecs[i].ehd, vecs[i].rd,
                   vecs[i].epc, vecs[i].st};
            $display("vec%0d rst=%b req=%b fb=%b sq=%b st=%b mt=%b base=%0d fl=%b rd=%b pc=%h",
                     i, vecs[i].rstn, vecs[i].req, vecs[i].fb, squash, dispatch_stall,
                     mt_restore_en, mt_restore_base, fl_restore_en, fetch_redirect,
                     redirect_pc);
            check($sformatf("vec%0d", i), got, exp);
        end

        // fu_busy stuck high: DRAIN times out at T+21 with a second squash
        reset = 1'b1; recover_req = 1'b1; recover_pc = 32'hDEAD_BEE0;
        recover_fl_head = 5'd31; fu_busy = 1'b1;
`ifdef RECOVER_PERF_CNT_EN
        c0 = recover_count; s0 = recover_stall_cycles;
`endif
        sq_first = -1; sq_second = -1; sq_n = 0; rd_cyc = -1; rd_pc = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            recover_req = 1'b0;
            if (squash) begin
                sq_n++;
                if (sq_n == 1) sq_first = c;
                else if (sq_n == 2) sq_second = c;
            end
            if (fetch_redirect) begin
                rd_cyc = c;
                rd_pc  = redirect_pc;
                break;
            end
        end
        $display("timeout seq squash_at=%0d,%0d redirect_at=%0d pc=%h",
                 sq_first, sq_second, rd_cyc, rd_pc);
        check("to_squash1_cycle", 64'(sq_first), 64'd1);
        check("to_squash2_cycle", 64'(sq_second), 64'd21);
        check("to_squash_count", 64'(sq_n), 64'd2);
        check("to_redirect_cycle", 64'(rd_cyc), 64'd22);
        check("to_redirect_pc", {32'd0, rd_pc}, 64'h0000_0000_DEAD_BEE0);
        @(negedge clock);
        fu_busy = 1'b0;
        check("to_idle_after", {62'd0, recover_busy, dispatch_stall}, 64'd0);
`ifdef RECOVER_PERF_CNT_EN
        check("perf_count_delta", {32'd0, recover_count - c0}, 64'd1);
        check("perf_stall_delta", {32'd0, recover_stall_cycles - s0}, 64'd22);
`endif

        // Reset clears everything, counters included
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("final_reset_busy", {63'd0, recover_busy}, 64'd0);
        check("final_reset_pc", {32'd0, redirect_pc}, 64'd0);
`ifdef RECOVER_PERF_CNT_EN
        check("perf_count_reset", {32'd0, recover_count}, 64'd0);
        check("perf_stall_reset", {32'd0, recover_stall_cycles}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
